apb_csr_top: RTL and testbench
==============================

// Module: apb_csr_top
// PURPOSE
//  APB-style slave with a small control/status register file: a read-only TYPE id, a
//  scratch RANDOM register, an interrupt clear, a sticky interrupt status and an interrupt mask.
//  Sits on the peripheral bus; a single external level interrupt source feeds INT_STATUS.
//  Zero-wait-state access; errors reported on slv_err.
// PARAMETERS
//  ADDRESS_SIZE     32     bus address width
//  REG_NUMBER       5      number of registers (all readable), offsets 0..REG_NUMBER-1
//  ADDR_BASE        4      block base; decoded as addr[ADDRESS_SIZE-1:BASE_BIT]==ADDR_BASE (0x400)
//  BASE_BIT         8      LSB of base field; register offset is addr[BASE_BIT-1:0]
//  WRITE_REG_NUMBER 3      number of writable registers (RANDOM, INT_CLR, MASK)
//  REG_WIDTH        8      data/register width
//  TYPE_DEFAULT     8'hAF  constant value of TYPE
//  RANDOM_DEFAULT   8'hAF  reset value of RANDOM
// PORTS
//  clk      in   1             clock, rising edge
//  rst_n    in   1             asynchronous active-low reset
//  addr     in   ADDRESS_SIZE  byte address
//  sel      in   1             PSEL
//  en       in   1             PENABLE
//  write    in   1             1=write, 0=read
//  wdata    in   REG_WIDTH     write data
//  rdata    out  REG_WIDTH     read data
//  ready    out  1             PREADY
//  slv_err  out  1             PSLVERR
//  intrpt   in   1             level interrupt request, sampled every clk
// BEHAVIOUR
//  Register map (offset): 0 TYPE RO =TYPE_DEFAULT; 1 RANDOM RW [7:0];
//   2 INT_CLR WO-pulse, bit7=clear, reads 0; 3 INT_STATUS RO, bit0 sticky; 4 MASK RW, bit0 only.
//  Unimplemented bits read 0. Reset: RANDOM=RANDOM_DEFAULT, INT_STATUS=0, MASK=0.
//  Setup phase sel=1,en=0: no effect, ready=0, slv_err=0, rdata=0.
//  Access phase sel=1,en=1: ready=1 combinationally (no wait states); transfer completes
//   at that rising clk edge; ready=0 whenever sel&en is false.
//  Read: rdata = selected register during access phase, else 0; rdata=0 on error.
//  Write: register updates at the access-phase clock edge only if no error.
//  slv_err=1 during access phase (with ready) when: base field != ADDR_BASE; offset >=
//   REG_NUMBER; or write to TYPE/INT_STATUS. Errored writes leave all state unchanged.
//  Interrupt: each clk, if intrpt && MASK[0] then INT_STATUS[0]<=1. Writing INT_CLR with
//   wdata[7]=1 clears INT_STATUS[0]. Same-cycle set and clear: set wins. Clearing MASK
//   does not clear a pending status. INT_CLR holds no state.
//  Asserting rst_n low mid-transfer aborts it; all state returns to reset values
//   immediately; outputs 0 while in reset.
// STRUCTURE
//  Shared package: offset constants (OFF_TYPE..OFF_MASK), INT_CLR_BIT=7, MASK_BIT=0,
//   STATUS_BIT=0.
//  One natural sub-module: apb_csr_decode (address window/offset decode, RO/range error
//   generation); register file and interrupt logic stay in top.
// TESTING
//  Reset, read 0x400..0x404 -> AF, AF, 00, 00, 00; slv_err=0; ready=1 only in access phase.
//  Write 0x401=0x02, read back -> 0x02; write 0x400=0x01 -> slv_err=1, TYPE still 0xAF.
//  Write 0x404=0x81 -> MASK reads 0x01; write 0x403=0x81 -> slv_err=1, status stays 0.
//  MASK=1, intrpt=1 -> INT_STATUS reads 0x01; intrpt=0, write 0x402=0x81 -> reads 0x00.
//  MASK=0, intrpt=1 -> status stays 0; intrpt=1 held during INT_CLR write -> status stays 1.
//  Access 0x405 and 0x500 (read and write) -> slv_err=1, rdata=0, no state change.

Source files
------------

// File: rtl/apb_csr_pkg.sv
// Shared constants for the APB control/status register block.
// Holds the register offsets inside the block window and the bit positions
// of the single-bit fields. The block's top and its address decoder both
// import this package.
package apb_csr_pkg;

  // Register offsets within the block window.
  localparam int OFF_TYPE       = 0;
  localparam int OFF_RANDOM     = 1;
  localparam int OFF_INT_CLR    = 2;
  localparam int OFF_INT_STATUS = 3;
  localparam int OFF_MASK       = 4;

  // Writable registers are RANDOM, INT_CLR and MASK.
  localparam int WRITE_REG_NUMBER = 3;

  // Bit positions of the single-bit fields.
  localparam int INT_CLR_BIT = 7;
  localparam int MASK_BIT    = 0;
  localparam int STATUS_BIT  = 0;

endpackage

// File: rtl/apb_csr_if.sv
// APB-style peripheral bus bundle used between a bus master and the CSR block.
//   addr, sel, en, write, wdata : master -> slave
//   rdata, ready, slv_err       : slave -> master
//
// Handshake: a transfer is a setup phase (sel=1, en=0) followed by an access
// phase (sel=1, en=1). The slave raises ready in the access phase with no wait
// states, so the transfer completes at the first rising clock edge that sees
// sel & en & ready. slv_err and rdata are only meaningful while ready is high;
// outside the access phase the slave drives all three to 0.
interface apb_csr_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int REG_WIDTH    = 8
);

  logic [ADDRESS_SIZE-1:0] addr;
  logic                    sel;
  logic                    en;
  logic                    write;
  logic [REG_WIDTH-1:0]    wdata;
  logic [REG_WIDTH-1:0]    rdata;
  logic                    ready;
  logic                    slv_err;

  modport master (
    output addr, sel, en, write, wdata,
    input  rdata, ready, slv_err
  );

  modport slave (
    input  addr, sel, en, write, wdata,
    output rdata, ready, slv_err
  );

endinterface

// File: rtl/apb_csr_decode.sv
// Address decode for the CSR block.
// Splits the byte address into a base field and a register offset, checks the
// base against the block window, the offset against the register count, and
// rejects writes to read-only registers.
//   addr   : bus byte address
//   write  : 1 for a write transfer
//   access : access phase active (sel & en)
//   offset : register offset, addr[BASE_BIT-1:0]
//   ok     : access phase to a legal register for this direction
//   err    : access phase that must be answered with slv_err
import apb_csr_pkg::*;

module apb_csr_decode #(
  parameter int ADDRESS_SIZE = 32,
  parameter int REG_NUMBER   = 5,
  parameter int ADDR_BASE    = 4,
  parameter int BASE_BIT     = 8
) (
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic                    write,
  input  logic                    access,
  output logic [BASE_BIT-1:0]     offset,
  output logic                    ok,
  output logic                    err
);

  localparam int BASE_W = ADDRESS_SIZE - BASE_BIT;

  logic base_hit;
  logic in_range;
  logic ro_hit;
  logic legal;

  assign offset   = addr[BASE_BIT-1:0];
  assign base_hit = (addr[ADDRESS_SIZE-1:BASE_BIT] == BASE_W'(ADDR_BASE));
  assign in_range = (int'(offset) < REG_NUMBER);
  assign ro_hit   = (int'(offset) == OFF_TYPE) || (int'(offset) == OFF_INT_STATUS);

  // A read of any implemented offset is legal; a write additionally needs a
  // writable target.
  assign legal = base_hit && in_range && !(write && ro_hit);

  assign ok  = access && legal;
  assign err = access && !legal;

endmodule

// File: rtl/apb_csr_top.sv
// APB-style control/status register slave.
// Registers (offset): 0 TYPE (RO constant), 1 RANDOM (RW scratch),
// 2 INT_CLR (write bit7=1 to clear the interrupt status, reads 0),
// 3 INT_STATUS (RO, bit0 sticky), 4 MASK (RW, bit0 enables the interrupt).
// Zero wait states: ready follows sel & en combinationally.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; outputs forced to 0 while low
//   intrpt : level interrupt request, sampled every clock
//   bus    : APB slave port (addr, sel, en, write, wdata, rdata, ready, slv_err)
import apb_csr_pkg::*;

module apb_csr_top #(
  parameter int                    ADDRESS_SIZE   = 32,
  parameter int                    REG_NUMBER     = 5,
  parameter int                    ADDR_BASE      = 4,
  parameter int                    BASE_BIT       = 8,
  parameter int                    REG_WIDTH      = 8,
  parameter logic [REG_WIDTH-1:0]  TYPE_DEFAULT   = 8'hAF,
  parameter logic [REG_WIDTH-1:0]  RANDOM_DEFAULT = 8'hAF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      intrpt,
  apb_csr_if.slave  bus
);

  logic                 access;
  logic [BASE_BIT-1:0]  offset;
  logic                 acc_ok;
  logic                 acc_err;

  logic [REG_WIDTH-1:0] random_q;
  logic                 mask_q;
  logic                 status_q;

  logic                 wr_random;
  logic                 wr_clr;
  logic                 wr_mask;
  logic                 clr_pulse;
  logic [REG_WIDTH-1:0] rdata_c;

  assign access = bus.sel && bus.en;

  apb_csr_decode #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .REG_NUMBER   (REG_NUMBER),
    .ADDR_BASE    (ADDR_BASE),
    .BASE_BIT     (BASE_BIT)
  ) u_decode (
    .addr   (bus.addr),
    .write  (bus.write),
    .access (access),
    .offset (offset),
    .ok     (acc_ok),
    .err    (acc_err)
  );

  // Write strobes; only legal access-phase writes reach the registers, so an
  // errored transfer leaves all state untouched.
  assign wr_random = acc_ok && bus.write && (int'(offset) == OFF_RANDOM);
  assign wr_clr    = acc_ok && bus.write && (int'(offset) == OFF_INT_CLR);
  assign wr_mask   = acc_ok && bus.write && (int'(offset) == OFF_MASK);
  assign clr_pulse = wr_clr && bus.wdata[INT_CLR_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_q <= RANDOM_DEFAULT;
      mask_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      if (wr_random) begin
        random_q <= bus.wdata;
      end
      if (wr_mask) begin
        mask_q <= bus.wdata[MASK_BIT];
      end
      // A masked-in request in the same cycle as a clear wins, so an event
      // arriving during the clear is never lost. Clearing MASK alone leaves a
      // pending status in place.
      if (intrpt && mask_q) begin
        status_q <= 1'b1;
      end else if (clr_pulse) begin
        status_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (acc_ok && !bus.write) begin
      case (int'(offset))
        OFF_TYPE:       rdata_c = TYPE_DEFAULT;
        OFF_RANDOM:     rdata_c = random_q;
        OFF_INT_STATUS: rdata_c[STATUS_BIT] = status_q;
        OFF_MASK:       rdata_c[MASK_BIT] = mask_q;
        default:        rdata_c = '0;
      endcase
    end
  end

  // Outputs are combinational from the bus; gating with rst_n keeps them at 0
  // for the whole reset, even if the master leaves a transfer asserted.
  assign bus.ready   = access && rst_n;
  assign bus.slv_err = acc_err && rst_n;
  assign bus.rdata   = rst_n ? rdata_c : '0;

endmodule

// File: tb/tb_apb_csr_top.sv
// Directed testbench for apb_csr_top: a table of transfers with hand-computed
// read data and error flags, followed by hand-written sequences for reset
// behaviour and a reset asserted in the middle of a transfer.
module tb_apb_csr_top;

  logic clk;
  logic rst_n;
  logic intrpt;

  apb_csr_if #(.ADDRESS_SIZE(32), .REG_WIDTH(8)) bus ();

  apb_csr_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .intrpt (intrpt),
    .bus    (bus)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [7:0]  wdata;
    logic        intr;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic i, input logic [7:0] er, input logic ee);
    vec_t v;
    v.addr = a; v.write = w; v.wdata = d; v.intr = i; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic bus_idle();
    bus.sel   = 1'b0;
    bus.en    = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  // One full setup+access transfer. Setup-phase outputs are checked here;
  // access-phase outputs are returned for the caller to compare.
  task automatic apb_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [7:0] d, input logic i,
                          output logic [7:0] rd, output logic er, output logic rdy);
    @(posedge clk); #1;
    intrpt    = i;
    bus.sel   = 1'b1;
    bus.en    = 1'b0;
    bus.addr  = a;
    bus.write = w;
    bus.wdata = d;
    @(negedge clk);
    check({tag, " setup ready"}, 32'(bus.ready), 32'd0);
    check({tag, " setup slv_err"}, 32'(bus.slv_err), 32'd0);
    check({tag, " setup rdata"}, 32'(bus.rdata), 32'd0);
    @(posedge clk); #1;
    bus.en = 1'b1;
    @(negedge clk);
    rd  = bus.rdata;
    er  = bus.slv_err;
    rdy = bus.ready;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic xfer_check(input string tag, input logic [31:0] a, input logic w,
                            input logic [7:0] d, input logic i,
                            input logic [7:0] exp_rd, input logic exp_er);
    logic [7:0] rd;
    logic       er;
    logic       rdy;
    apb_xfer(tag, a, w, d, i, rd, er, rdy);
    check({tag, " ready"}, 32'(rdy), 32'd1);
    check({tag, " slv_err"}, 32'(er), 32'(exp_er));
    check({tag, " rdata"}, 32'(rd), 32'(exp_rd));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    rst_n  = 1'b0;
    intrpt = 1'b0;
    bus_idle();

    // Outputs held at 0 during reset even with an access phase on the bus.
    repeat (2) @(posedge clk);
    #1;
    bus.sel  = 1'b1;
    bus.en   = 1'b1;
    bus.addr = 32'h400;
    @(negedge clk);
    check("in reset ready", 32'(bus.ready), 32'd0);
    check("in reset slv_err", 32'(bus.slv_err), 32'd0);
    check("in reset rdata", 32'(bus.rdata), 32'd0);
    @(posedge clk); #1;
    bus_idle();
    rst_n = 1'b1;

    // Idle bus with en alone must not raise ready.
    #1 bus.en = 1'b1;
    @(negedge clk);
    check("idle en-only ready", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    bus_idle();

    //    addr      wr    wdata  intr  exp_rd exp_err
    add(32'h400, 1'b0, 8'h00, 1'b0, 8'hAF, 1'b0);  // TYPE
    add(32'h401, 1'b0, 8'h00, 1'b0, 8'hAF, 1'b0);  // RANDOM reset
    add(32'h402, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);  // INT_CLR reads 0
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);  // INT_STATUS reset
    add(32'h404, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);  // MASK reset
    add(32'h401, 1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    add(32'h401, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0);
    add(32'h400, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1);  // TYPE is read-only
    add(32'h400, 1'b0, 8'h00, 1'b0, 8'hAF, 1'b0);
    add(32'h404, 1'b1, 8'h81, 1'b0, 8'h00, 1'b0);
    add(32'h404, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);  // only bit0 kept
    add(32'h403, 1'b1, 8'h81, 1'b0, 8'h00, 1'b1);  // INT_STATUS read-only
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(32'h403, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);  // masked-in request sets
    add(32'h402, 1'b1, 8'h81, 1'b0, 8'h00, 1'b0);  // clear
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(32'h404, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);  // MASK=0
    add(32'h403, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);  // masked out
    add(32'h403, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    add(32'h404, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);  // MASK=1
    add(32'h403, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
    add(32'h402, 1'b1, 8'h80, 1'b1, 8'h00, 1'b0);  // set beats clear
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
    add(32'h404, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);  // MASK=0 keeps pending
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
    add(32'h405, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);  // offset out of range
    add(32'h405, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    add(32'h500, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);  // wrong base
    add(32'h501, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    add(32'h401, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0);  // unchanged by errors
    add(32'h404, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(32'h402, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b0);  // bit7=0: no clear
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
    add(32'h402, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0);
    add(32'h403, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(32'h402, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    add(32'h401, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    add(32'h401, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b0);

    foreach (vecs[k]) begin
      xfer_check($sformatf("vec%0d @%0h", k, vecs[k].addr), vecs[k].addr, vecs[k].write,
                 vecs[k].wdata, vecs[k].intr, vecs[k].exp_rdata, vecs[k].exp_err);
    end

    // Reset asserted in the access phase of a write: the write is dropped and
    // every register, including a pending status, returns to reset values.
    xfer_check("pre-rst mask", 32'h404, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    xfer_check("pre-rst status", 32'h403, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
    @(posedge clk); #1;
    bus.sel   = 1'b1;
    bus.en    = 1'b0;
    bus.addr  = 32'h401;
    bus.write = 1'b1;
    bus.wdata = 8'h55;
    @(posedge clk); #1;
    bus.en = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid-rst ready", 32'(bus.ready), 32'd0);
    check("mid-rst slv_err", 32'(bus.slv_err), 32'd0);
    check("mid-rst rdata", 32'(bus.rdata), 32'd0);
    @(posedge clk); #1;
    bus_idle();
    rst_n = 1'b1;
    xfer_check("post-rst random", 32'h401, 1'b0, 8'h00, 1'b1, 8'hAF, 1'b0);
    xfer_check("post-rst status", 32'h403, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    xfer_check("post-rst mask", 32'h404, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
